// File: rtl/obc_heartbeat_supervisor_pkg.sv
// Shared definitions for the OBC heartbeat supervisor: channel FSM encoding,
// default timing constants and parameter sanity helpers.
package obc_heartbeat_supervisor_pkg;

  typedef enum logic [1:0] {
    ST_DISARMED = 2'd0,
    ST_HOLDOFF  = 2'd1,
    ST_ARMED    = 2'd2,
    ST_FAULT    = 2'd3
  } hb_state_e;

  localparam int DEF_TIMEOUT_CYCLES = 1000000;
  localparam int DEF_HOLDOFF_CYCLES = 2000000;
  localparam int DEF_MISS_LIMIT     = 3;
  localparam int DEF_CNT_W          = 27;

  // The timer only ever holds values 0 .. cycles-1, so that range must fit.
  function automatic bit cycles_fit(input longint cycles, input int width);
    return (cycles >= 1) && (((cycles - 1) >> width) == 0);
  endfunction

  function automatic bit miss_limit_ok(input int limit);
    return (limit >= 1) && (limit <= 7);
  endfunction

endpackage

// File: rtl/obc_heartbeat_supervisor_hb_watchdog_channel.sv
// One heartbeat watchdog channel: pin synchronizer, toggle detector,
// blanking/timeout FSM, miss counter and registered fault pulse.
module hb_watchdog_channel
  import obc_heartbeat_supervisor_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  parameter int HOLDOFF_CYCLES = DEF_HOLDOFF_CYCLES,
  parameter int MISS_LIMIT     = DEF_MISS_LIMIT,
  parameter int CNT_W          = DEF_CNT_W
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic       hb,
  input  logic       clear,
  output logic       error,
  output logic       fault,
  output logic [2:0] miss
);

  if (!cycles_fit(longint'(TIMEOUT_CYCLES), CNT_W) ||
      !cycles_fit(longint'(HOLDOFF_CYCLES), CNT_W) ||
      !miss_limit_ok(MISS_LIMIT)) begin : g_bad_params
    $error("hb_watchdog_channel: illegal timing parameters");
  end

  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLDOFF_LAST = CNT_W'(HOLDOFF_CYCLES - 1);
  localparam logic [2:0]       MISS_MAX     = 3'(MISS_LIMIT);

  logic             sync1;
  logic             sync2;
  logic             hb_prev;
  logic [1:0]       settle;
  logic             hb_event;
  hb_state_e        state;
  logic [CNT_W-1:0] timer;
  logic [2:0]       miss_cnt;

  // The edge register starts at 0 while the pin may already be high, so the
  // first toggle seen after reset is masked until the chain has refilled.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1   <= 1'b0;
      sync2   <= 1'b0;
      hb_prev <= 1'b0;
      settle  <= 2'd0;
    end else begin
      sync1   <= hb;
      sync2   <= sync1;
      hb_prev <= sync2;
      if (settle != 2'd3) settle <= settle + 2'd1;
    end
  end

  assign hb_event = (sync2 ^ hb_prev) && (settle == 2'd3);

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_DISARMED;
      timer    <= '0;
      miss_cnt <= 3'd0;
      error    <= 1'b0;
    end else begin
      error <= 1'b0;
      if (!enable) begin
        state    <= ST_DISARMED;
        timer    <= '0;
        miss_cnt <= 3'd0;
      end else begin
        case (state)
          ST_DISARMED: begin
            state    <= ST_HOLDOFF;
            timer    <= '0;
            miss_cnt <= 3'd0;
          end
          ST_HOLDOFF: begin
            if (timer == HOLDOFF_LAST) begin
              state    <= ST_ARMED;
              timer    <= '0;
              miss_cnt <= 3'd0;
            end else begin
              timer <= timer + 1'b1;
            end
          end
          ST_ARMED: begin
            // A heartbeat beats a coinciding timeout: no miss is counted.
            if (hb_event) begin
              timer    <= '0;
              miss_cnt <= 3'd0;
            end else if (timer == TIMEOUT_LAST) begin
              timer <= '0;
              if (miss_cnt + 3'd1 >= MISS_MAX) begin
                state    <= ST_FAULT;
                miss_cnt <= MISS_MAX;
                error    <= 1'b1;
              end else begin
                miss_cnt <= miss_cnt + 3'd1;
              end
            end else begin
              timer <= timer + 1'b1;
            end
          end
          ST_FAULT: begin
            timer <= '0;
            if (clear) begin
              state    <= ST_HOLDOFF;
              miss_cnt <= 3'd0;
            end
          end
          default: begin
            state    <= ST_DISARMED;
            timer    <= '0;
            miss_cnt <= 3'd0;
          end
        endcase
      end
    end
  end

  assign fault = (state == ST_FAULT);
  assign miss  = miss_cnt;

endmodule

// File: rtl/obc_heartbeat_supervisor.sv
// Dual-microcontroller heartbeat supervisor: two identical, independent
// watchdog channels feeding the selector's error inputs.
module obc_heartbeat_supervisor
  import obc_heartbeat_supervisor_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  parameter int HOLDOFF_CYCLES = DEF_HOLDOFF_CYCLES,
  parameter int MISS_LIMIT     = DEF_MISS_LIMIT,
  parameter int CNT_W          = DEF_CNT_W
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic       hb_uc1,
  input  logic       hb_uc2,
  input  logic       clear_uc1,
  input  logic       clear_uc2,
  output logic       error_uc1,
  output logic       error_uc2,
  output logic       fault_uc1,
  output logic       fault_uc2,
  output logic [2:0] miss_uc1,
  output logic [2:0] miss_uc2
);

  hb_watchdog_channel #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
    .HOLDOFF_CYCLES(HOLDOFF_CYCLES),
    .MISS_LIMIT    (MISS_LIMIT),
    .CNT_W         (CNT_W)
  ) u_ch1 (
    .clk   (clk),
    .reset (reset),
    .enable(enable),
    .hb    (hb_uc1),
    .clear (clear_uc1),
    .error (error_uc1),
    .fault (fault_uc1),
    .miss  (miss_uc1)
  );

  hb_watchdog_channel #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
    .HOLDOFF_CYCLES(HOLDOFF_CYCLES),
    .MISS_LIMIT    (MISS_LIMIT),
    .CNT_W         (CNT_W)
  ) u_ch2 (
    .clk   (clk),
    .reset (reset),
    .enable(enable),
    .hb    (hb_uc2),
    .clear (clear_uc2),
    .error (error_uc2),
    .fault (fault_uc2),
    .miss  (miss_uc2)
  );

endmodule

// File: tb/tb_obc_heartbeat_supervisor.sv
// Bench for obc_heartbeat_supervisor: directed scenarios plus random heartbeat
// traffic, checked against a time-based reference model and an error scoreboard.
module tb_obc_heartbeat_supervisor;

  localparam int TO = 16;
  localparam int HO = 8;
  localparam int ML = 2;
  localparam int CW = 8;

  localparam int M_OFF   = 0;
  localparam int M_BLANK = 1;
  localparam int M_WATCH = 2;
  localparam int M_FAULT = 3;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       enable = 1'b0;
  logic       hb_uc1 = 1'b0;
  logic       hb_uc2 = 1'b0;
  logic       clear_uc1 = 1'b0;
  logic       clear_uc2 = 1'b0;
  logic       error_uc1;
  logic       error_uc2;
  logic       fault_uc1;
  logic       fault_uc2;
  logic [2:0] miss_uc1;
  logic [2:0] miss_uc2;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [31:0] exp_q1[$];
  logic [31:0] exp_q2[$];

  int mode[2];
  int watch_start[2];
  int ref_t[2];
  bit h0[2];
  bit h1[2];
  bit h2[2];
  int exp_fault[2];
  int exp_miss[2];

  obc_heartbeat_supervisor #(
    .TIMEOUT_CYCLES(TO),
    .HOLDOFF_CYCLES(HO),
    .MISS_LIMIT    (ML),
    .CNT_W         (CW)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .enable   (enable),
    .hb_uc1   (hb_uc1),
    .hb_uc2   (hb_uc2),
    .clear_uc1(clear_uc1),
    .clear_uc2(clear_uc2),
    .error_uc1(error_uc1),
    .error_uc2(error_uc2),
    .fault_uc1(fault_uc1),
    .fault_uc2(fault_uc2),
    .miss_uc1 (miss_uc1),
    .miss_uc2 (miss_uc2)
  );

  // Clock and reset
  always #5 clk = ~clk;

  // Reference model. A pin level sampled at edge k is seen as a heartbeat at
  // edge k+2. While watching, misses are elapsed time since the last heartbeat
  // (or arming) divided by the timeout; a fault is that time reaching
  // TO*ML cycles.
  initial begin
    for (int c = 0; c < 2; c++) begin
      mode[c] = M_OFF; watch_start[c] = 0; ref_t[c] = 0;
      h0[c] = 0; h1[c] = 0; h2[c] = 0; exp_fault[c] = 0; exp_miss[c] = 0;
    end
    forever begin
      @(posedge clk);
      cyc = cyc + 1;
      for (int c = 0; c < 2; c++) begin
        bit pin;
        bit clr;
        bit ev;
        pin = (c == 0) ? hb_uc1 : hb_uc2;
        clr = (c == 0) ? clear_uc1 : clear_uc2;
        ev  = h1[c] ^ h2[c];
        if (reset) begin
          h0[c] = 0; h1[c] = 0; h2[c] = 0;
          mode[c] = M_OFF;
        end else begin
          h2[c] = h1[c]; h1[c] = h0[c]; h0[c] = pin;
          if (!enable) mode[c] = M_OFF;
          else begin
            case (mode[c])
              M_OFF: begin
                mode[c] = M_BLANK;
                watch_start[c] = cyc + HO;
              end
              M_BLANK: begin
                if (cyc == watch_start[c]) begin
                  mode[c] = M_WATCH;
                  ref_t[c] = cyc;
                end
              end
              M_WATCH: begin
                if (ev) ref_t[c] = cyc;
                else if (cyc - ref_t[c] == TO * ML) begin
                  mode[c] = M_FAULT;
                  if (c == 0) exp_q1.push_back(32'(cyc));
                  else exp_q2.push_back(32'(cyc));
                end
              end
              default: begin
                if (clr) begin
                  mode[c] = M_BLANK;
                  watch_start[c] = cyc + HO;
                end
              end
            endcase
          end
        end
        exp_fault[c] = (mode[c] == M_FAULT) ? 1 : 0;
        if (mode[c] == M_WATCH) exp_miss[c] = (cyc - ref_t[c]) / TO;
        else if (mode[c] == M_FAULT) exp_miss[c] = ML;
        else exp_miss[c] = 0;
      end
    end
  end

  task automatic check(input string name, input int act, input int exp);
    checks = checks + 1;
    if (act != exp) begin
      errors = errors + 1;
      $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, exp);
    end
  endtask

  // Monitor: level outputs every cycle, error pulses against the scoreboard.
  initial begin
    forever begin
      @(negedge clk);
      check("fault_uc1", int'(fault_uc1), exp_fault[0]);
      check("fault_uc2", int'(fault_uc2), exp_fault[1]);
      check("miss_uc1", int'(miss_uc1), exp_miss[0]);
      check("miss_uc2", int'(miss_uc2), exp_miss[1]);
      if (error_uc1) begin
        if (exp_q1.size() == 0) check("error_uc1 unexpected", 1, 0);
        else check("error_uc1 cycle", cyc, int'(exp_q1.pop_front()));
      end else if (exp_q1.size() > 0 && int'(exp_q1[0]) <= cyc) begin
        check("error_uc1 missing", 0, 1);
        void'(exp_q1.pop_front());
      end
      if (error_uc2) begin
        if (exp_q2.size() == 0) check("error_uc2 unexpected", 1, 0);
        else check("error_uc2 cycle", cyc, int'(exp_q2.pop_front()));
      end else if (exp_q2.size() > 0 && int'(exp_q2[0]) <= cyc) begin
        check("error_uc2 missing", 0, 1);
        void'(exp_q2.pop_front());
      end
    end
  end

  // Driver tasks
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_clear(input bit c1, input bit c2);
    clear_uc1 = c1;
    clear_uc2 = c2;
    tick(1);
    clear_uc1 = 1'b0;
    clear_uc2 = 1'b0;
  endtask

  initial begin
    int rate;
    // Reset wins over enable and clear on the same edges.
    reset = 1'b1; enable = 1'b1; clear_uc1 = 1'b1; clear_uc2 = 1'b1;
    tick(3);
    clear_uc1 = 1'b0; clear_uc2 = 1'b0;
    reset = 1'b0; enable = 1'b0;
    tick(2);

    // uC1 alive every 10 cycles, uC2 silent -> faults, is cleared,
    // toggles during blanking, then faults again.
    enable = 1'b1;
    for (int i = 0; i < 500; i++) begin
      if (i % 10 == 9) hb_uc1 = ~hb_uc1;
      clear_uc2 = (i == 100);
      if (i > 100 && i < 110) hb_uc2 = ~hb_uc2;
      tick(1);
    end
    clear_uc2 = 1'b0;

    // Drop enable mid-ARMED, with a clear in the same cycle.
    enable = 1'b0; clear_uc1 = 1'b1;
    tick(1);
    clear_uc1 = 1'b0;
    tick(2);

    // Both silent -> simultaneous faults; clear both; reset mid-HOLDOFF.
    enable = 1'b1;
    tick(60);
    pulse_clear(1'b1, 1'b1);
    tick(4);
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    tick(3);

    // Heartbeat landing exactly on the last timer count (uC1), one cycle
    // late (uC2).
    enable = 1'b0;
    tick(2);
    enable = 1'b1;
    tick(1);
    tick(20);
    for (int i = 0; i < 12 * 17; i++) begin
      if (i % 16 == 0) hb_uc1 = ~hb_uc1;
      if (i % 17 == 0) hb_uc2 = ~hb_uc2;
      tick(1);
    end

    // Random traffic with varying heartbeat density.
    for (int seg = 0; seg < 8; seg++) begin
      case ($urandom_range(0, 2))
        0: rate = 4;
        1: rate = 14;
        default: rate = 30;
      endcase
      for (int i = 0; i < 400; i++) begin
        if ($urandom_range(0, rate - 1) == 0) hb_uc1 = ~hb_uc1;
        if ($urandom_range(0, rate - 1) == 0) hb_uc2 = ~hb_uc2;
        clear_uc1 = ($urandom_range(0, 29) == 0);
        clear_uc2 = ($urandom_range(0, 29) == 0);
        enable = ($urandom_range(0, 199) != 0);
        reset = ($urandom_range(0, 699) == 0);
        tick(1);
      end
    end
    reset = 1'b0; enable = 1'b1; clear_uc1 = 1'b0; clear_uc2 = 1'b0;
    tick(5);

    check("pending error_uc1", exp_q1.size(), 0);
    check("pending error_uc2", exp_q2.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
